// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter: FSM state encodings,
// requester IDs and default configuration values.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    RQ_CPU = 1'b0,
    RQ_ALU = 1'b1
  } rq_id_t;

  localparam int          DATA_WIDTH_DEFAULT = 8;
  localparam int          ADDR_WIDTH_DEFAULT = 20;
  localparam int unsigned INT_LIMIT_DEFAULT  = 32'h0000_0100;
  localparam int          TIMEOUT_DEFAULT    = 1024;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester handshakes (CPU = index 0, ALU = index 1) and the
// shared memory port of the arbiter.
//   Requester side : reqN, weN, addrN, wdataN -> gntN, doneN, errN, rdata
//   Memory side    : mem_req, mem_ext, mem_we, mem_addr, mem_wdata
//                    <- mem_ack, mem_rdata
//   Status         : busy
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 20
);

  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  done0;
  logic                  err0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  done1;
  logic                  err1;

  logic [DATA_WIDTH-1:0] rdata;

  logic                  mem_req;
  logic                  mem_ext;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, done0, err0,
    output gnt1, done1, err1,
    output rdata,
    output mem_req, mem_ext, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, done0, err0,
    input  gnt1, done1, err1,
    input  rdata,
    input  mem_req, mem_ext, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/arb_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
// Loadable down-counter bounding how long the arbiter waits for mem_ack.
// Loaded with TIMEOUT-1 while the arbiter is in GRANT and decremented once per
// ACCESS cycle, so 'expired' rises in the TIMEOUT-th ACCESS cycle.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-low reset
//   load     in  reload the counter with TIMEOUT-1
//   en       in  count down one step (saturates at zero)
//   expired  out counter has reached zero
// -----------------------------------------------------------------------------
module arb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  // TIMEOUT-1 always fits in $clog2(TIMEOUT) bits for TIMEOUT >= 2.
  localparam int            CW    = $clog2(TIMEOUT);
  localparam logic [CW-1:0] START = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // NOTE: clocked state is assigned with <= so every flop samples the values
  // from before the edge; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= START;
    end else if (load) begin
      cnt <= START;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port (internal RAM below INT_LIMIT, SPI external memory at
// or above it) between the CPU requester (index 0) and the ALU engine
// (index 1). Each transaction runs IDLE -> GRANT -> ACCESS -> RESP -> IDLE:
// a one-cycle gnt pulse, a memory access held until mem_ack (or watchdog
// abort), then a one-cycle done pulse with rdata.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset (0 = reset)
//   bus    slave modport of mem_port_arbiter_if (requesters, memory, busy)
// Configuration:
//   ARB_ROUND_ROBIN_EN defined   - ties go to the requester not granted last.
//   ARB_ROUND_ROBIN_EN undefined - ties always go to the ALU (req1).
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int          ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned INT_LIMIT  = INT_LIMIT_DEFAULT,
  parameter int          TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(INT_LIMIT);

  state_t                state_q;
  state_t                state_d;
  rq_id_t                owner_q;
  rq_id_t                last_gnt_q;
  rq_id_t                winner;

  logic                  any_req;
  logic                  expired;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  we_q;
  logic                  ext_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  assign any_req = bus.req0 | bus.req1;

  // ---------------------------------------------------------------------------
  // Winner select. With no request the winner simply tracks the last grant;
  // it is only consumed when a request is present.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the branches so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = last_gnt_q;
    if (bus.req0 && !bus.req1) begin
      winner = RQ_CPU;
    end else if (bus.req1 && !bus.req0) begin
      winner = RQ_ALU;
    end else if (bus.req0 && bus.req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_gnt_q == RQ_CPU) ? RQ_ALU : RQ_CPU;
`else
      winner = RQ_ALU;
`endif
    end
  end

  // Request fields of the captured owner.
  always_comb begin
    if (owner_q == RQ_ALU) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end else begin
      sel_we    = bus.we0;
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: reloaded in GRANT, counts ACCESS cycles.
  // ---------------------------------------------------------------------------
  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (state_q == ST_GRANT),
    .en      (state_q == ST_ACCESS),
    .expired (expired)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Request drops mid-transaction are deliberately ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_GRANT;
      ST_GRANT:  state_d = ST_ACCESS;
      // An ack in the expiry cycle still counts as success.
      ST_ACCESS: if (bus.mem_ack || expired) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the current state.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.gnt0    = 1'b0;
    bus.gnt1    = 1'b0;
    bus.done0   = 1'b0;
    bus.done1   = 1'b0;
    bus.err0    = 1'b0;
    bus.err1    = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    unique case (state_q)
      ST_GRANT: begin
        bus.gnt0 = (owner_q == RQ_CPU);
        bus.gnt1 = (owner_q == RQ_ALU);
      end
      ST_ACCESS: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = we_q;
      end
      ST_RESP: begin
        bus.done0 = (owner_q == RQ_CPU);
        bus.done1 = (owner_q == RQ_ALU);
        bus.err0  = (owner_q == RQ_CPU) && err_q;
        bus.err1  = (owner_q == RQ_ALU) && err_q;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rdata     = rdata_q;
  assign bus.mem_ext   = ext_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // ---------------------------------------------------------------------------
  // Datapath latches: owner and pointer, request capture, response capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= RQ_CPU;
      last_gnt_q <= RQ_ALU;  // so the CPU wins the first round-robin tie
      we_q       <= 1'b0;
      ext_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) owner_q <= winner;
        end
        ST_GRANT: begin
          last_gnt_q <= owner_q;
          we_q       <= sel_we;
          addr_q     <= sel_addr;
          wdata_q    <= sel_wdata;
          ext_q      <= (sel_addr >= LIMIT);
          err_q      <= 1'b0;
        end
        ST_ACCESS: begin
          if (bus.mem_ack) begin
            // Writes leave the previous read data visible.
            if (!we_q) rdata_q <= bus.mem_rdata;
          end else if (expired) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Two instances: 'dut' with the default
// TIMEOUT of 1024 and 'dut_t' with TIMEOUT = 16 for the watchdog cases.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected tie winner follows ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit FIRST = 1'b0;  // CPU wins the first tie after reset
`else
  localparam bit FIRST = 1'b1;  // ALU always wins ties
`endif

  mem_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(20)) bus   ();
  mem_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(20)) bus_t ();

  mem_port_arbiter #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (20),
    .INT_LIMIT  (32'h100),
    .TIMEOUT    (1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_port_arbiter #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (20),
    .INT_LIMIT  (32'h100),
    .TIMEOUT    (16)
  ) dut_t (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_t)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_req(input bit id, input bit v, input bit we,
                           input logic [19:0] a, input logic [7:0] wd);
    if (id) begin
      bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
    end else begin
      bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
    end
  endtask

  // Single request on the main instance; memory acks after wait_n extra
  // ACCESS cycles (0 = ack in the first ACCESS cycle).
  task automatic txn(input string tag, input bit id, input bit we,
                     input logic [19:0] a, input logic [7:0] wd, input int wait_n,
                     input logic [7:0] rd, input bit exp_ext, input logic [7:0] exp_rdata);
    drive_req(id, 1'b1, we, a, wd);
    step();
    check({tag, "_gnt"}, id ? bus.gnt1 : bus.gnt0, 1);
    step();
    check({tag, "_ext"},   bus.mem_ext,   exp_ext);
    check({tag, "_addr"},  bus.mem_addr,  a);
    check({tag, "_we"},    bus.mem_we,    we);
    check({tag, "_wdata"}, bus.mem_wdata, wd);
    repeat (wait_n) step();
    check({tag, "_mem_req"}, bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    check({tag, "_done"},  id ? bus.done1 : bus.done0, 1);
    check({tag, "_err"},   id ? bus.err1  : bus.err0,  0);
    check({tag, "_rdata"}, bus.rdata, exp_rdata);
    drive_req(id, 1'b0, 1'b0, 20'h0, 8'h00);
    step();
    check({tag, "_idle"},  bus.busy, 0);
    check({tag, "_rdata_hold"}, bus.rdata, exp_rdata);
  endtask

  initial begin
    reset = 1'b0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    bus_t.req0 = 0; bus_t.we0 = 0; bus_t.addr0 = '0; bus_t.wdata0 = '0;
    bus_t.req1 = 0; bus_t.we1 = 0; bus_t.addr1 = '0; bus_t.wdata1 = '0;
    bus_t.mem_ack = 0; bus_t.mem_rdata = '0;

    // Reset state
    repeat (2) step();
    check("rst_busy",    bus.busy,    0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_gnt",     {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 0);
    check("rst_rdata",   bus.rdata,   0);
    check("rst_addr",    bus.mem_addr, 0);
    reset = 1'b1;
    step();
    check("idle_busy", bus.busy, 0);

    // 1: internal write, done three cycles after the request
    txn("t1", 1'b0, 1'b1, 20'h00010, 8'h55, 0, 8'h00, 1'b0, 8'h00);
    // 2: external read at exactly INT_LIMIT, ack in the 20th ACCESS cycle
    txn("t2", 1'b0, 1'b0, 20'h00100, 8'h00, 19, 8'hAA, 1'b1, 8'hAA);
    // 6: INT_LIMIT-1 is internal; external write keeps the previous rdata
    txn("t6a", 1'b0, 1'b0, 20'h000FF, 8'h00, 0, 8'h33, 1'b0, 8'h33);
    txn("t6b", 1'b1, 1'b1, 20'h00100, 8'h77, 0, 8'hEE, 1'b1, 8'h33);

    // 6: stray ack while idle
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h99;
    step();
    check("stray_busy",  bus.busy, 0);
    check("stray_done",  {bus.done0, bus.done1, bus.gnt0, bus.gnt1}, 0);
    check("stray_rdata", bus.rdata, 8'h33);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    step();
    check("stray_idle",  bus.busy, 0);

    // 3: simultaneous requests, twice
    for (int r = 0; r < 2; r++) begin
      drive_req(1'b0, 1'b1, 1'b0, 20'h00020, 8'h00);
      drive_req(1'b1, 1'b1, 1'b0, 20'h00030, 8'h00);
      step();
      check("tie_gnt0", bus.gnt0, !FIRST);
      check("tie_gnt1", bus.gnt1, FIRST);
      step();
      check("tie_addr1", bus.mem_addr, FIRST ? 20'h00030 : 20'h00020);
      bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
      step();
      bus.mem_ack = 1'b0;
      check("tie_done1", FIRST ? bus.done1 : bus.done0, 1);
      check("tie_rdata1", bus.rdata, 8'h11);
      drive_req(FIRST, 1'b0, 1'b0, 20'h0, 8'h00);
      step();
      check("tie_gap", bus.busy, 0);
      step();
      check("tie_gnt_second", FIRST ? bus.gnt0 : bus.gnt1, 1);
      step();
      check("tie_addr2", bus.mem_addr, FIRST ? 20'h00020 : 20'h00030);
      bus.mem_ack = 1'b1; bus.mem_rdata = 8'h22;
      step();
      bus.mem_ack = 1'b0;
      check("tie_done2", FIRST ? bus.done0 : bus.done1, 1);
      check("tie_rdata2", bus.rdata, 8'h22);
      drive_req(!FIRST, 1'b0, 1'b0, 20'h0, 8'h00);
      step();
      check("tie_end", bus.busy, 0);
    end

    // 5: reset during ACCESS of req1
    drive_req(1'b1, 1'b1, 1'b0, 20'h00040, 8'h00);
    step();
    check("r5_gnt1", bus.gnt1, 1);
    step();
    check("r5_mem_req", bus.mem_req, 1);
    reset = 1'b0;
    #1;
    check("r5_busy",    bus.busy,     0);
    check("r5_mem_req0", bus.mem_req, 0);
    check("r5_addr",    bus.mem_addr, 0);
    check("r5_rdata",   bus.rdata,    0);
    step();
    check("r5_no_done", {bus.done1, bus.done0, bus.busy}, 0);
    reset = 1'b1;
    step();
    check("r5_regnt", bus.gnt1, 1);
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h66;
    step();
    bus.mem_ack = 1'b0;
    check("r5_done",  bus.done1, 1);
    check("r5_rdata2", bus.rdata, 8'h66);
    drive_req(1'b1, 1'b0, 1'b0, 20'h0, 8'h00);
    step();

    // 4a: TIMEOUT=16, ack arrives in the expiry cycle -> success
    bus_t.req0 = 1'b1; bus_t.we0 = 1'b0; bus_t.addr0 = 20'h00200;
    step();
    check("t4a_gnt", bus_t.gnt0, 1);
    step();
    check("t4a_ext", bus_t.mem_ext, 1);
    repeat (15) step();
    check("t4a_req16", bus_t.mem_req, 1);
    bus_t.mem_ack = 1'b1; bus_t.mem_rdata = 8'h5A;
    step();
    bus_t.mem_ack = 1'b0; bus_t.mem_rdata = 8'h00;
    check("t4a_done",  bus_t.done0, 1);
    check("t4a_err",   bus_t.err0,  0);
    check("t4a_rdata", bus_t.rdata, 8'h5A);
    bus_t.req0 = 1'b0;
    step();

    // 4b: TIMEOUT=16, no ack -> abort after 16 ACCESS cycles
    bus_t.req0 = 1'b1;
    step();
    check("t4b_gnt", bus_t.gnt0, 1);
    step();
    repeat (15) step();
    check("t4b_req16", bus_t.mem_req, 1);
    check("t4b_no_done", bus_t.done0, 0);
    step();
    check("t4b_req_drop", bus_t.mem_req, 0);
    check("t4b_done",  bus_t.done0, 1);
    check("t4b_err",   bus_t.err0,  1);
    check("t4b_rdata", bus_t.rdata, 8'h00);
    bus_t.req0 = 1'b0;
    step();
    check("t4b_idle", {bus_t.busy, bus_t.err0, bus_t.done0}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
